// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core control path.
// Contents:
//   - opcode values
//   - sequencer state encodings, which are also the o_state debug values
//   - fault codes
//   - watchdog counter width
//   - illegal-opcode helper function
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_RDMEM = 4'd6;
  localparam logic [3:0] OP_WRMEM = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_JMPA  = 4'd12;
  localparam logic [3:0] OP_JMPR  = 4'd13;

  // Wide enough for any MEM_TIMEOUT in 1..255.
  localparam int WD_W = 8;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_REGREAD   = 4'd3,
    S_EXECUTE   = 4'd4,
    S_MEMORY    = 4'd5,
    S_WRITEBACK = 4'd6,
    S_BRANCH    = 4'd7,
    S_HALT      = 4'd8,
    S_FAULT     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_TIMEOUT = 2'b01,
    FC_ILLEGAL = 2'b10
  } fault_code_t;

  // Opcodes 14 and 15 are unassigned and trap.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_JMPR);
  endfunction

endpackage

// File: rtl/ctrl_wdog.sv
// Memory-handshake watchdog for the sequencer.
// The counter is cleared on every state change and otherwise advances
// while i_count is high.
// Ports:
//   i_clk     - clock
//   i_rst     - synchronous active-high reset
//   i_clear   - zero the counter (state change)
//   i_count   - count this cycle (sequencer is waiting on memory)
//   o_expire  - this is the MEM_TIMEOUT-th cycle spent waiting
module ctrl_wdog
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // cnt_q holds the number of cycles already spent in the state.
  // Expiry therefore fires during the MEM_TIMEOUT-th cycle, so a ready in
  // that same cycle still wins in the sequencer.
  assign o_expire = i_count && (cnt_q == WD_W'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_count) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit RISC core.
// Each instruction steps through:
//   FETCH -> DECODE -> REGREAD -> EXECUTE -> (MEMORY | BRANCH | WRITEBACK)
// Ports:
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_opcode          - decoder opcode, latched at the end of DECODE
//   i_shldBranch      - ALU branch decision, used in BRANCH
//   i_mem_ready       - memory handshake done (fetch or data access)
//   i_halt            - stop at the next instruction boundary
//   o_en_*            - per-stage enables
//   o_mem_we          - data memory write, qualifies o_en_mem
//   o_pc_inc          - PC increment pulse
//   o_pc_load         - PC load pulse (from the ALU result)
//   o_state           - current state (debug)
//   o_fault           - fault flag (sticky until reset)
//   o_fault_code      - fault reason
//   o_retired         - retired-instruction count, wraps to 0
module alu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_opcode,
  input  logic             i_shldBranch,
  input  logic             i_mem_ready,
  input  logic             i_halt,
  output logic             o_en_fetch,
  output logic             o_en_decode,
  output logic             o_en_regread,
  output logic             o_en_alu,
  output logic             o_en_mem,
  output logic             o_mem_we,
  output logic             o_en_regwrite,
  output logic             o_pc_inc,
  output logic             o_pc_load,
  output logic [3:0]       o_state,
  output logic             o_fault,
  output logic [1:0]       o_fault_code,
  output logic [CNT_W-1:0] o_retired
);

  state_t            state_q, state_d;
  fault_code_t       code_q, code_d;
  logic [3:0]        opcode_q;
  logic [CNT_W-1:0]  retired_q;
  logic              retire;
  logic              wd_expire;
  logic              wd_count;
  logic              wd_clear;

  assign wd_count = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign wd_clear = (state_d != state_q);

  ctrl_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (wd_clear),
    .i_count (wd_count),
    .o_expire(wd_expire)
  );

  // Next state and outputs.
  // Outputs are a Moore decode of state_q and opcode_q, with two
  // exceptions that follow the inputs combinationally:
  //   - o_pc_inc on a completing store (follows i_mem_ready in MEMORY)
  //   - o_pc_inc / o_pc_load in BRANCH (follow i_shldBranch)
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    retire        = 1'b0;
    o_en_fetch    = 1'b0;
    o_en_decode   = 1'b0;
    o_en_regread  = 1'b0;
    o_en_alu      = 1'b0;
    o_en_mem      = 1'b0;
    o_mem_we      = 1'b0;
    o_en_regwrite = 1'b0;
    o_pc_inc      = 1'b0;
    o_pc_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = i_halt ? S_HALT : S_FETCH;
      end

      S_FETCH: begin
        o_en_fetch = 1'b1;
        if (i_mem_ready) begin
          state_d = S_DECODE;
        end else if (wd_expire) begin
          state_d = S_FAULT;
          code_d  = FC_TIMEOUT;
        end
      end

      S_DECODE: begin
        o_en_decode = 1'b1;
        if (is_illegal(i_opcode)) begin
          state_d = S_FAULT;
          code_d  = FC_ILLEGAL;
        end else begin
          state_d = S_REGREAD;
        end
      end

      S_REGREAD: begin
        o_en_regread = 1'b1;
        state_d      = S_EXECUTE;
      end

      S_EXECUTE: begin
        o_en_alu = 1'b1;
        case (opcode_q)
          OP_RDMEM, OP_WRMEM: state_d = S_MEMORY;
          OP_JMPA, OP_JMPR:   state_d = S_BRANCH;
          default:            state_d = S_WRITEBACK;
        endcase
      end

      S_MEMORY: begin
        o_en_mem = 1'b1;
        o_mem_we = (opcode_q == OP_WRMEM);
        if (i_mem_ready) begin
          // A store has nothing to write back, so it retires here.
          if (opcode_q == OP_WRMEM) begin
            o_pc_inc = 1'b1;
            retire   = 1'b1;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wd_expire) begin
          state_d = S_FAULT;
          code_d  = FC_TIMEOUT;
        end
      end

      S_WRITEBACK: begin
        o_en_regwrite = 1'b1;
        o_pc_inc      = 1'b1;
        retire        = 1'b1;
      end

      S_BRANCH: begin
        o_pc_load = i_shldBranch;
        o_pc_inc  = !i_shldBranch;
        retire    = 1'b1;
      end

      S_HALT: begin
        if (!i_halt) begin
          state_d = S_FETCH;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Instruction boundary: a completed instruction heads back to FETCH
    // unless a halt is pending. Leaving IDLE or HALT retires nothing.
    if (retire) begin
      state_d = i_halt ? S_HALT : S_FETCH;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      code_q    <= FC_NONE;
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      if (state_q == S_DECODE) begin
        opcode_q <= i_opcode;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign o_state      = state_q;
  assign o_fault      = (state_q == S_FAULT);
  assign o_fault_code = code_q;
  assign o_retired    = retired_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl.
// Expected {state, enables} traces are queued per cycle, then drained
// against the DUT one clock at a time.
// CNT_W is reduced to 3 so that the retired-count wrap is reachable.
module tb_alu_seq_ctrl;
  import cpu_pkg::*;

  localparam int CNT_W = 3;
  localparam int W     = 13;

  // Enable vector bits:
  //   {fetch, decode, regread, alu, mem, we, regwrite, pc_inc, pc_load}
  localparam logic [8:0] O_NONE = 9'h000;
  localparam logic [8:0] O_F    = 9'h100;
  localparam logic [8:0] O_D    = 9'h080;
  localparam logic [8:0] O_R    = 9'h040;
  localparam logic [8:0] O_E    = 9'h020;
  localparam logic [8:0] O_M    = 9'h010;
  localparam logic [8:0] O_MW   = 9'h018;
  localparam logic [8:0] O_WB   = 9'h006;
  localparam logic [8:0] O_INC  = 9'h002;
  localparam logic [8:0] O_LD   = 9'h001;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       opcode;
  logic             shld;
  logic             ready;
  logic             halt;
  logic             en_fetch, en_decode, en_regread, en_alu, en_mem, mem_we;
  logic             en_regwrite, pc_inc, pc_load, fault;
  logic [3:0]       state;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] retired;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  alu_seq_ctrl #(
    .MEM_TIMEOUT(15),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opcode     (opcode),
    .i_shldBranch (shld),
    .i_mem_ready  (ready),
    .i_halt       (halt),
    .o_en_fetch   (en_fetch),
    .o_en_decode  (en_decode),
    .o_en_regread (en_regread),
    .o_en_alu     (en_alu),
    .o_en_mem     (en_mem),
    .o_mem_we     (mem_we),
    .o_en_regwrite(en_regwrite),
    .o_pc_inc     (pc_inc),
    .o_pc_load    (pc_load),
    .o_state      (state),
    .o_fault      (fault),
    .o_fault_code (fault_code),
    .o_retired    (retired)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {en_fetch, en_decode, en_regread, en_alu, en_mem, mem_we,
            en_regwrite, pc_inc, pc_load};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input state_t st, input logic [8:0] o);
    exp_q.push_back({st, o});
  endtask

  task automatic push_inst(input state_t last_st, input logic [8:0] last_o);
    push(S_FETCH, O_F);
    push(S_DECODE, O_D);
    push(S_REGREAD, O_R);
    push(S_EXECUTE, O_E);
    push(last_st, last_o);
  endtask

  // Scoreboard: one queued entry per cycle, sampled mid-cycle.
  task automatic drain(input string tag);
    logic [W-1:0] e;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      chk($sformatf("%s[%0d].state", tag, i), 32'(state), 32'(e[12:9]));
      chk($sformatf("%s[%0d].outs", tag, i), 32'(outs()), 32'(e[8:0]));
      i++;
      step();
    end
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 4'd0;
    shld   = 1'b0;
    ready  = 1'b0;
    halt   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.state", 32'(state), 32'(S_IDLE));
    chk("reset.outs", 32'(outs()), 32'(O_NONE));
    chk("reset.retired", 32'(retired), 32'd0);
    chk("reset.fault", 32'(fault), 32'd0);
    chk("reset.code", 32'(fault_code), 32'd0);
    rst = 1'b0;

    // Zero-wait ADD
    ready = 1'b1;
    push(S_IDLE, O_NONE);
    push_inst(S_WRITEBACK, O_WB);
    drain("add");
    chk("add.retired", 32'(retired), 32'd1);

    // Store with 3 wait cycles
    opcode = OP_WRMEM;
    push(S_FETCH, O_F);
    push(S_DECODE, O_D);
    push(S_REGREAD, O_R);
    push(S_EXECUTE, O_E);
    drain("wr_pre");
    ready = 1'b0;
    repeat (3) push(S_MEMORY, O_MW);
    drain("wr_wait");
    ready = 1'b1;
    push(S_MEMORY, O_MW | O_INC);
    drain("wr_done");
    chk("wr.state", 32'(state), 32'(S_FETCH));
    chk("wr.retired", 32'(retired), 32'd2);

    // JMPR taken then not taken
    opcode = OP_JMPR;
    shld   = 1'b1;
    push_inst(S_BRANCH, O_LD);
    drain("jmp_taken");
    chk("jmp_taken.retired", 32'(retired), 32'd3);
    shld = 1'b0;
    push_inst(S_BRANCH, O_INC);
    drain("jmp_not");
    chk("jmp_not.retired", 32'(retired), 32'd4);

    // Halt raised during EXECUTE of OR
    opcode = OP_OR;
    push(S_FETCH, O_F);
    push(S_DECODE, O_D);
    push(S_REGREAD, O_R);
    drain("or_pre");
    halt = 1'b1;
    push(S_EXECUTE, O_E);
    push(S_WRITEBACK, O_WB);
    drain("or_halt");
    chk("halt.retired", 32'(retired), 32'd5);
    repeat (3) push(S_HALT, O_NONE);
    drain("halt_hold");
    halt = 1'b0;
    push(S_HALT, O_NONE);
    push(S_FETCH, O_F);
    drain("halt_release");

    // Three CMPs: 5 -> 6 -> 7 -> wraps to 0
    opcode = OP_CMP;
    push(S_DECODE, O_D);
    push(S_REGREAD, O_R);
    push(S_EXECUTE, O_E);
    push(S_WRITEBACK, O_WB);
    repeat (2) push_inst(S_WRITEBACK, O_WB);
    drain("cmp");
    chk("cmp.retired_wrap", 32'(retired), 32'd0);

    // Zero-wait load from memory
    opcode = OP_RDMEM;
    push_inst(S_MEMORY, O_M);
    push(S_WRITEBACK, O_WB);
    drain("rd");
    chk("rd.retired", 32'(retired), 32'd1);

    // Reset in the middle of a load's MEMORY wait
    push(S_FETCH, O_F);
    push(S_DECODE, O_D);
    push(S_REGREAD, O_R);
    push(S_EXECUTE, O_E);
    drain("rd2_pre");
    ready = 1'b0;
    repeat (2) push(S_MEMORY, O_M);
    drain("rd2_wait");
    rst = 1'b1;
    #1;
    chk("rd2_rst.outs", 32'(outs()), 32'(O_M));
    step();
    #1;
    chk("rd2_rst.state", 32'(state), 32'(S_IDLE));
    chk("rd2_rst.outs_idle", 32'(outs()), 32'(O_NONE));
    chk("rd2_rst.retired", 32'(retired), 32'd0);
    rst = 1'b0;

    // Illegal opcode 14
    ready  = 1'b1;
    opcode = 4'd14;
    push(S_IDLE, O_NONE);
    push(S_FETCH, O_F);
    push(S_DECODE, O_D);
    drain("ill");
    chk("ill.fault", 32'(fault), 32'd1);
    chk("ill.code", 32'(fault_code), 32'(FC_ILLEGAL));
    ready = 1'b0;
    repeat (20) push(S_FAULT, O_NONE);
    drain("ill_hold");
    chk("ill_hold.code", 32'(fault_code), 32'(FC_ILLEGAL));
    chk("ill_hold.fault", 32'(fault), 32'd1);
    do_reset();
    chk("ill_rst.state", 32'(state), 32'(S_IDLE));
    chk("ill_rst.code", 32'(fault_code), 32'd0);
    chk("ill_rst.fault", 32'(fault), 32'd0);

    // Fetch timeout after exactly 15 cycles in FETCH
    opcode = OP_ADD;
    push(S_IDLE, O_NONE);
    repeat (15) push(S_FETCH, O_F);
    drain("tmo");
    chk("tmo.state", 32'(state), 32'(S_FAULT));
    chk("tmo.code", 32'(fault_code), 32'(FC_TIMEOUT));
    do_reset();

    // Ready in the 15th FETCH cycle still succeeds
    push(S_IDLE, O_NONE);
    repeat (14) push(S_FETCH, O_F);
    drain("edge_wait");
    ready = 1'b1;
    push(S_FETCH, O_F);
    drain("edge_ready");
    chk("edge.state", 32'(state), 32'(S_DECODE));
    chk("edge.code", 32'(fault_code), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
